buffered_stream_sink: RTL and testbench



---
 rtl/sink_config.sv | 19 +
 rtl/sink_fifo.sv | 48 ++++
 rtl/buffered_stream_sink.sv | 82 ++++++++
 tb/tb_buffered_stream_sink.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sink_config.sv
// Shared configuration for the network output sink: widths, beat counts and
// the padded word type stored per output vector.
package sink_config;

  localparam int NET_NUM_OUT = 12;
  localparam int SNK_WIDTH   = 8;
  localparam int SNK_DEPTH   = 4;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  localparam int SNK_BEATS       = ceil_div(NET_NUM_OUT, SNK_WIDTH);
  localparam int SNK_TOTAL       = SNK_BEATS * SNK_WIDTH;
  localparam int MAX_OUT_PER_RUN = SNK_DEPTH;

  typedef logic [SNK_TOTAL-1:0] snk_word_t;

endpackage

// File: rtl/sink_fifo.sv
// Generic synchronous first-word-fall-through FIFO; dout always shows the head.
module sink_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) bits, so they wrap without extra logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/buffered_stream_sink.sv
// Buffers network output vectors, bit-reverses them and serialises each into
// MSB-first host beats, flagging the last beat of every vector.
module buffered_stream_sink
  import sink_config::*;
#(
  parameter int NUM_OUT   = NET_NUM_OUT,
  parameter int SNK_WIDTH = sink_config::SNK_WIDTH,
  parameter int DEPTH     = SNK_DEPTH,
  localparam int LW       = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 net_valid,
  output logic                 net_ready,
  input  logic [NUM_OUT-1:0]   net_out,
  input  logic                 snk_ready,
  output logic                 snk_valid,
  output logic [SNK_WIDTH-1:0] snk,
  output logic                 snk_last,
  output logic [LW-1:0]        level
);

  localparam int BEATS = (NUM_OUT + SNK_WIDTH - 1) / SNK_WIDTH;
  localparam int TOTAL = BEATS * SNK_WIDTH;
  localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [NUM_OUT-1:0] w;
  logic [TOTAL-1:0]   p;
  logic [TOTAL-1:0]   head;
  logic [TOTAL-1:0]   shifted;
  logic [KW-1:0]      k;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               hs;
  logic               last_beat;

  // Output neuron 0 lands in the MSB; padding fills the LSB end.
  always_comb begin
    w = '0;
    for (int i = 0; i < NUM_OUT; i++) w[NUM_OUT-1-i] = net_out[i];
    p = '0;
    p[TOTAL-1 -: NUM_OUT] = w;
  end

  assign net_ready = !full && !rst;
  assign push      = net_valid && net_ready;
  assign snk_valid = !empty;
  assign last_beat = (k == KW'(BEATS - 1));
  assign hs        = snk_valid && snk_ready;
  assign pop       = hs && last_beat;

  sink_fifo #(
    .WIDTH (TOTAL),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (p),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (level)
  );

  // Beat k is taken from the top of the head word shifted left by k beats.
  assign shifted  = head << (k * SNK_WIDTH);
  assign snk      = snk_valid ? shifted[TOTAL-1 -: SNK_WIDTH] : '0;
  assign snk_last = snk_valid && last_beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      k <= '0;
    end else if (hs) begin
      k <= last_beat ? '0 : k + 1'b1;
    end
  end

endmodule

// File: tb/tb_buffered_stream_sink.sv
// Directed bench for buffered_stream_sink with 12 outputs, 8-bit beats, depth 4.
module tb_buffered_stream_sink;

  localparam int NUM_OUT   = 12;
  localparam int SNK_WIDTH = 8;
  localparam int DEPTH     = 4;
  localparam int LW        = $clog2(DEPTH + 1);

  logic                 clk;
  logic                 rst;
  logic                 net_valid;
  logic                 net_ready;
  logic [NUM_OUT-1:0]   net_out;
  logic                 snk_ready;
  logic                 snk_valid;
  logic [SNK_WIDTH-1:0] snk;
  logic                 snk_last;
  logic [LW-1:0]        level;

  int checks = 0;
  int errors = 0;

  buffered_stream_sink #(
    .NUM_OUT   (NUM_OUT),
    .SNK_WIDTH (SNK_WIDTH),
    .DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .net_valid (net_valid),
    .net_ready (net_ready),
    .net_out   (net_out),
    .snk_ready (snk_ready),
    .snk_valid (snk_valid),
    .snk       (snk),
    .snk_last  (snk_last),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] vec;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference padded word: bit i of the vector goes to bit 15-i.
  function automatic logic [15:0] model(input logic [11:0] v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 12; i++) r[15-i] = v[i];
    return r;
  endfunction

  function automatic logic [7:0] beat_of(input logic [11:0] v, input int b);
    logic [15:0] m;
    m = model(v);
    return (b == 0) ? m[15:8] : m[7:0];
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_hold(input logic [11:0] v);
    net_valid = 1'b1;
    net_out   = v;
    cyc();
    net_valid = 1'b0;
  endtask

  logic [11:0] fv [5];
  logic [11:0] sv [2];

  initial begin
    rst       = 1'b1;
    net_valid = 1'b0;
    net_out   = '0;
    snk_ready = 1'b0;

    tbl[0] = '{12'h001, 8'h80, 8'h00};
    tbl[1] = '{12'hABC, 8'h3D, 8'h50};
    tbl[2] = '{12'hFFF, 8'hFF, 8'hF0};
    tbl[3] = '{12'h800, 8'h00, 8'h10};
    tbl[4] = '{12'h0F0, 8'h0F, 8'h00};
    tbl[5] = '{12'h123, 8'hC4, 8'h80};

    @(negedge clk);
    cyc();
    check("rst_net_ready", 32'(net_ready), 32'd0);
    check("rst_snk_valid", 32'(snk_valid), 32'd0);
    check("rst_snk",       32'(snk),       32'd0);
    check("rst_snk_last",  32'(snk_last),  32'd0);
    check("rst_level",     32'(level),     32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_net_ready", 32'(net_ready), 32'd1);
    @(negedge clk);

    // Table: one vector at a time with the host always ready.
    for (int t = 0; t < 6; t++) begin
      net_valid = 1'b1;
      net_out   = tbl[t].vec;
      snk_ready = 1'b1;
      cyc();
      net_valid = 1'b0;
      check("tbl_valid0", 32'(snk_valid), 32'd1);
      check("tbl_beat0",  32'(snk),       32'(tbl[t].b0));
      check("tbl_last0",  32'(snk_last),  32'd0);
      check("tbl_level0", 32'(level),     32'd1);
      cyc();
      check("tbl_beat1",  32'(snk),       32'(tbl[t].b1));
      check("tbl_last1",  32'(snk_last),  32'd1);
      check("tbl_level1", 32'(level),     32'd1);
      cyc();
      check("tbl_empty",  32'(snk_valid), 32'd0);
      check("tbl_level2", 32'(level),     32'd0);
    end

    // Fill while the host stalls; the fifth vector must wait for a pop.
    fv[0] = 12'h101; fv[1] = 12'h202; fv[2] = 12'h303; fv[3] = 12'h404; fv[4] = 12'h505;
    snk_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_hold(fv[i]);
    net_valid = 1'b1;
    net_out   = fv[4];
    check("full_net_ready", 32'(net_ready), 32'd0);
    check("full_level",     32'(level),     32'd4);
    check("full_snk",       32'(snk),       32'(beat_of(fv[0], 0)));
    for (int c = 0; c < 10; c++) begin
      cyc();
      check("stall_snk",   32'(snk),      32'(beat_of(fv[0], 0)));
      check("stall_last",  32'(snk_last), 32'd0);
      check("stall_level", 32'(level),    32'd4);
    end
    begin
      int got;
      int first_ready_at;
      bit accepted;
      bit push_now;
      got = 0;
      first_ready_at = -1;
      accepted = 1'b0;
      snk_ready = 1'b1;
      for (int c = 0; c < 40 && got < 10; c++) begin
        if (!accepted && net_ready && first_ready_at < 0) first_ready_at = got;
        if (snk_valid && snk_ready) begin
          check("drain_snk",  32'(snk),      32'(beat_of(fv[got/2], got % 2)));
          check("drain_last", 32'(snk_last), 32'(got % 2));
          got++;
        end
        push_now = net_valid && net_ready;
        cyc();
        if (push_now) begin
          accepted  = 1'b1;
          net_valid = 1'b0;
        end
      end
      check("drain_count",     32'(got),            32'd10);
      check("fifth_accept_at", 32'(first_ready_at), 32'd2);
      check("drain_empty",     32'(snk_valid),      32'd0);
      check("drain_level",     32'(level),          32'd0);
    end

    // Ready toggling 1,0,1 advances exactly one beat per high cycle.
    snk_ready = 1'b0;
    push_hold(12'hABC);
    check("tog_start", 32'(snk), 32'h3D);
    snk_ready = 1'b1;
    cyc();
    check("tog_adv1",      32'(snk),      32'h50);
    check("tog_adv1_last", 32'(snk_last), 32'd1);
    snk_ready = 1'b0;
    cyc();
    check("tog_hold",       32'(snk),   32'h50);
    check("tog_hold_level", 32'(level), 32'd1);
    snk_ready = 1'b1;
    cyc();
    check("tog_done_valid", 32'(snk_valid), 32'd0);
    check("tog_done_level", 32'(level),     32'd0);

    // Push coinciding with a final-beat pop keeps level and order.
    snk_ready = 1'b0;
    push_hold(12'h111);
    push_hold(12'h222);
    check("sim_level_pre", 32'(level), 32'd2);
    snk_ready = 1'b1;
    cyc();
    check("sim_last_beat", 32'(snk),      32'(beat_of(12'h111, 1)));
    check("sim_last_flag", 32'(snk_last), 32'd1);
    net_valid = 1'b1;
    net_out   = 12'h333;
    cyc();
    net_valid = 1'b0;
    check("sim_level_post", 32'(level), 32'd2);
    sv[0] = 12'h222; sv[1] = 12'h333;
    for (int j = 0; j < 4; j++) begin
      check("sim_order_snk",  32'(snk),      32'(beat_of(sv[j/2], j % 2)));
      check("sim_order_last", 32'(snk_last), 32'(j % 2));
      cyc();
    end
    check("sim_empty", 32'(snk_valid), 32'd0);

    // Reset in the middle of a vector discards everything.
    snk_ready = 1'b0;
    push_hold(12'h0A5);
    push_hold(12'h5A0);
    push_hold(12'hF00);
    check("mid_level", 32'(level), 32'd3);
    snk_ready = 1'b1;
    cyc();
    check("mid_beat1", 32'(snk), 32'(beat_of(12'h0A5, 1)));
    snk_ready = 1'b0;
    rst = 1'b1;
    cyc();
    check("mid_rst_valid", 32'(snk_valid), 32'd0);
    check("mid_rst_level", 32'(level),     32'd0);
    check("mid_rst_ready", 32'(net_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_post_ready", 32'(net_ready), 32'd1);
    @(negedge clk);
    push_hold(12'h3C3);
    check("mid_new_valid", 32'(snk_valid), 32'd1);
    check("mid_new_beat0", 32'(snk),       32'(beat_of(12'h3C3, 0)));
    check("mid_new_last",  32'(snk_last),  32'd0);
    check("mid_new_level", 32'(level),     32'd1);
    snk_ready = 1'b1;
    cyc();
    check("mid_new_beat1", 32'(snk), 32'(beat_of(12'h3C3, 1)));
    cyc();
    check("mid_final_level", 32'(level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
